md_sched: RTL and testbench
===========================

Name: md_sched

Overview:
- Multi-cycle multiply/divide sequencer for the five-stage pipeline; owns the HI/LO registers.
- Accepts one operation per start pulse from the EX stage and holds busy for a fixed latency. The hazard unit uses busy to stall later mult/div/mfhi/mflo instructions in ID.
- Results are committed to HI/LO atomically at the end of the operation.
- An issue blocked by a cancel (interrupt/exception flush) leaves no architectural effect.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous active-low reset
- start  input  1  issue strobe from EX-stage controller, one cycle per instruction
- op  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 see Optional Feature
- a  input  32  forwarded rs operand
- b  input  32  forwarded rt operand
- cancel  input  1  pipeline flush (interrupt taken), blocks issue this cycle
- busy  output  1  operation in flight
- done  output  1  one-cycle pulse in the cycle HI/LO take the new result
- hi  output  32  HI register
- lo  output  32  LO register
- issue_err  output  1  one-cycle pulse when start arrives while busy (sticky-free)

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low.
- Reset values: state IDLE, counter 0, busy 0, done 0, issue_err 0, hi 0, lo 0, pending regs 0.
- States:
  - IDLE: no operation in flight.
  - RUN: counter counts down.
  - FIN: one cycle, commits the result.
- Issue:
  - An issue is accepted when start=1, cancel=0 and state=IDLE.
  - cancel=1 drops start silently: no state change, no done, no issue_err.
- Accepted mult/multu/div/divu:
  - Compute the 64-bit result combinationally from a/b; latch it into pend_hi/pend_lo; load counter with LATENCY-1 (MULT_CYCLES or DIV_CYCLES).
  - busy=1 from the next cycle.
  - Next state is RUN, or FIN if LATENCY=1.
- RUN: decrement counter each cycle; on counter==1 go to FIN.
- FIN:
  - hi<=pend_hi, lo<=pend_lo, done=1, busy still 1.
  - Next state IDLE.
  - busy is high for exactly LATENCY cycles.
- Accepted mthi/mtlo:
  - Write a to hi or lo at the same edge; no busy, no done.
  - Other register unchanged.
- Arithmetic:
  - mult: signed 32x32 into {hi,lo}.
  - multu: unsigned 32x32 into {hi,lo}.
  - div: lo=signed quotient truncated toward zero; hi=remainder with the sign of a.
  - divu: unsigned quotient and remainder.
- Division by zero: lo=32'hFFFFFFFF, hi=a, normal latency.
- Signed overflow (a=32'h80000000, b=32'hFFFFFFFF, div): lo=32'h80000000, hi=0.
- start while busy: ignored, issue_err pulses one cycle, in-flight operation unaffected.
- cancel while busy: ignored; an accepted operation always completes (it was already past the flush point).
- hi/lo read combinationally from registers. During busy they hold the old values; the hazard unit must stall readers.
- Reset mid-operation: immediate return to reset values; the pending result is discarded.
- Undefined op 6/7 with feature disabled: accepted as no-op, no busy, no error.

Optional Feature:
- Macro MD_SCHED_MADD_EN.
- When defined:
  - op 6 = madd: {hi,lo} <= {hi,lo} + signed(a)*signed(b).
  - op 7 = maddu: same with unsigned product.
  - Both use MULT_CYCLES latency.
  - The accumulate uses the HI/LO value at the issue edge. No other writer can intervene while busy, so the result equals the value at FIN.
- When not defined: op 6/7 are no-ops per Behaviour and the accumulate adder is absent.

Test Plan:
- Reset: deassert reset, check hi=0, lo=0, busy=0. Then mult a=32'hFFFFFFFE, b=3:
  - busy high 5 cycles, done pulses in the 5th;
  - hi=32'hFFFFFFFF, lo=32'hFFFFFFFA.
- divu a=100, b=7:
  - busy 10 cycles;
  - lo=14, hi=2.
  - Then div a=-7, b=2: lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
- Divide edge cases:
  - div a=5, b=0: lo=32'hFFFFFFFF, hi=5.
  - div a=32'h80000000, b=32'hFFFFFFFF: lo=32'h80000000, hi=0.
- start with cancel=1 (mult 2x2): no busy, hi/lo unchanged. Then mthi a=32'h1234 with cancel=0: hi=32'h1234 next edge, lo unchanged.
- Busy conflicts:
  - During a busy mult, pulse start with divu: issue_err 1 cycle, mult result correct, busy length unchanged.
  - Assert reset at cycle 3 of a div: busy=0 immediately, hi/lo=0, no done.
- With MD_SCHED_MADD_EN, preload hi=0, lo=10 via mtlo, then madd a=3, b=4: after 5 cycles hi=0, lo=22.

Source files
------------

// File: rtl/md_sched_if.sv
// Issue/result bundle between the EX-stage controller and the mult/div sequencer.
// start is a one-cycle valid; it is taken only while busy=0 and cancel=0 (busy acts as not-ready).
interface md_sched_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        issue_err;
  logic [1:0]  state;

  modport master (
    output start, op, a, b, cancel,
    input  busy, done, hi, lo, issue_err, state
  );

  modport slave (
    input  start, op, a, b, cancel,
    output busy, done, hi, lo, issue_err, state
  );
endinterface

// File: rtl/md_sched.sv
// Multi-cycle multiply/divide sequencer owning HI/LO; commits results atomically in FIN.
// Define MD_SCHED_MADD_EN to enable madd/maddu (op 6/7) accumulating into {hi,lo}.
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  md_sched_if.slave  md
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
`ifdef MD_SCHED_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MADDU = 3'd7;
`endif

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        accept;
  logic        long_op;
  logic [3:0]  lat_load;
  logic [63:0] result;

  // Full 64-bit products; the low 64 bits of a sign-extended product equal the signed product.
  logic [63:0] a_sx, b_sx, prod_s, prod_u;
  assign a_sx   = {{32{md.a[31]}}, md.a};
  assign b_sx   = {{32{md.b[31]}}, md.b};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, md.a} * {32'd0, md.b};

  // One shared unsigned divider; signed div works on magnitudes and fixes signs afterwards.
  logic        signed_div;
  logic [31:0] dvd_mag, dvs_mag, quo_mag, rem_mag, quo, rem;
  assign signed_div = (md.op == OP_DIV);
  assign dvd_mag    = (signed_div && md.a[31]) ? (~md.a + 32'd1) : md.a;
  assign dvs_mag    = (signed_div && md.b[31]) ? (~md.b + 32'd1) : md.b;
  assign quo_mag    = dvd_mag / dvs_mag;
  assign rem_mag    = dvd_mag % dvs_mag;
  assign quo        = (signed_div && (md.a[31] ^ md.b[31])) ? (~quo_mag + 32'd1) : quo_mag;
  assign rem        = (signed_div && md.a[31]) ? (~rem_mag + 32'd1) : rem_mag;

  always_comb begin
    result = 64'd0;
    case (md.op)
      OP_MULT:  result = prod_s;
      OP_MULTU: result = prod_u;
      OP_DIV, OP_DIVU: begin
        if (md.b == 32'd0) result = {md.a, 32'hFFFF_FFFF};
        else               result = {rem, quo};
      end
`ifdef MD_SCHED_MADD_EN
      OP_MADD:  result = {hi_q, lo_q} + prod_s;
      OP_MADDU: result = {hi_q, lo_q} + prod_u;
`endif
      default:  result = 64'd0;
    endcase
  end

  always_comb begin
    long_op = 1'b0;
    case (md.op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: long_op = 1'b1;
`ifdef MD_SCHED_MADD_EN
      OP_MADD, OP_MADDU: long_op = 1'b1;
`endif
      default: long_op = 1'b0;
    endcase
  end

  assign lat_load = (md.op == OP_DIV || md.op == OP_DIVU) ? DIV_LOAD : MULT_LOAD;
  assign accept   = md.start && !md.cancel && (state_q == IDLE);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (long_op) begin
            {pend_hi_d, pend_lo_d} = result;
            cnt_d   = lat_load;
            state_d = (lat_load == 4'd0) ? FIN : RUN;
          end else if (md.op == OP_MTHI) begin
            hi_d = md.a;
          end else if (md.op == OP_MTLO) begin
            lo_d = md.a;
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = FIN;
      end
      FIN: begin
        hi_d    = pend_hi_q;
        lo_d    = pend_lo_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign md.busy      = (state_q != IDLE);
  assign md.done      = (state_q == FIN);
  assign md.issue_err = md.start && !md.cancel && (state_q != IDLE);
  assign md.hi        = hi_q;
  assign md.lo        = lo_q;
  assign md.state     = state_q;

endmodule

// File: tb/tb_md_sched.sv
// Directed bench for md_sched: expected {hi,lo} results are queued at issue and
// checked by a monitor one cycle after each done pulse.
module tb_md_sched;

  logic clk;
  logic reset;
  md_sched_if bus();

  md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (bus.slave)
  );

  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_cur;
  bit          cmp_pending = 0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor / scoreboard: hi/lo hold the committed result one cycle after done
  always @(negedge clk) begin
    if (cmp_pending) begin
      cmp_pending = 0;
      check("result_hilo", {bus.hi, bus.lo}, exp_cur);
    end
    if (bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_cur     = exp_q.pop_front();
        cmp_pending = 1;
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input logic c);
    @(posedge clk); #1;
    bus.start  = 1'b1;
    bus.op     = o;
    bus.a      = x;
    bus.b      = y;
    bus.cancel = c;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
  endtask

  // Issue a long op and measure busy length / done position; optionally
  // fire a conflicting start during the first busy cycle.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int lat, input logic [63:0] exp, input bit inject);
    int n = 0;
    int dn = 0;
    int dpos = 0;
    exp_q.push_back(exp);
    issue(o, x, y, 1'b0);
    if (inject) begin
      bus.start = 1'b1;
      bus.op    = 3'd3;
      bus.a     = 32'd9;
      bus.b     = 32'd3;
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (inject && i == 0) begin
        check("issue_err_pulse", {63'd0, bus.issue_err}, 64'd1);
        bus.start = 1'b0;
      end
      if (inject && i == 1) check("issue_err_clear", {63'd0, bus.issue_err}, 64'd0);
      if (bus.busy === 1'b1) begin
        n++;
        if (bus.done === 1'b1) begin
          dn++;
          dpos = n;
        end
      end else begin
        break;
      end
    end
    check("busy_len", 64'(n), 64'(lat));
    check("done_count", 64'(dn), 64'd1);
    check("done_pos", 64'(dpos), 64'(lat));
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.op     = 3'd0;
    bus.a      = 32'd0;
    bus.b      = 32'd0;
    bus.cancel = 1'b0;
    reset      = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
    check("reset_busy", {63'd0, bus.busy}, 64'd0);
    check("reset_state", {62'd0, bus.state}, 64'd0);
    check("reset_done_err", {62'd0, bus.done, bus.issue_err}, 64'd0);

    run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 5, 64'hFFFF_FFFF_FFFF_FFFA, 0);   // mult -2*3
    run_op(3'd3, 32'd100, 32'd7, 10, {32'd2, 32'd14}, 0);                 // divu
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 10, 64'hFFFF_FFFF_FFFF_FFFD, 0);   // div -7/2
    run_op(3'd2, 32'd5, 32'd0, 10, {32'd5, 32'hFFFF_FFFF}, 0);            // div by zero
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 64'hFFFF_FFFE_0000_0001, 0);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, {32'd0, 32'h8000_0000}, 0);

    // cancelled issue leaves no effect
    issue(3'd0, 32'd2, 32'd2, 1'b1);
    @(negedge clk);
    check("cancel_busy", {63'd0, bus.busy}, 64'd0);
    check("cancel_hilo", {bus.hi, bus.lo}, {32'd0, 32'h8000_0000});

    issue(3'd4, 32'h1234, 32'd0, 1'b0);
    check("mthi", {bus.hi, bus.lo}, {32'h1234, 32'h8000_0000});
    check("mthi_busy", {63'd0, bus.busy}, 64'd0);
    issue(3'd5, 32'hA5A5_0001, 32'd0, 1'b0);
    check("mtlo", {bus.hi, bus.lo}, {32'h1234, 32'hA5A5_0001});

    run_op(3'd0, 32'd7, 32'd6, 5, {32'd0, 32'd42}, 1);                    // start while busy

    // reset in the third busy cycle of a div
    issue(3'd2, 32'd20, 32'd3, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("midreset_busy", {63'd0, bus.busy}, 64'd0);
    check("midreset_hilo", {bus.hi, bus.lo}, 64'd0);
    check("midreset_done", {63'd0, bus.done}, 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    check("postreset_hilo", {bus.hi, bus.lo}, 64'd0);
    check("postreset_busy", {63'd0, bus.busy}, 64'd0);

`ifdef MD_SCHED_MADD_EN
    issue(3'd4, 32'd0, 32'd0, 1'b0);
    issue(3'd5, 32'd10, 32'd0, 1'b0);
    run_op(3'd6, 32'd3, 32'd4, 5, {32'd0, 32'd22}, 0);
`else
    issue(3'd5, 32'd10, 32'd0, 1'b0);
    issue(3'd6, 32'd3, 32'd4, 1'b0);
    @(negedge clk);
    check("op6_noop_busy", {62'd0, bus.busy, bus.issue_err}, 64'd0);
    check("op6_noop_hilo", {bus.hi, bus.lo}, {32'd0, 32'd10});
`endif

    repeat (3) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
